sc_game_timer: RTL and testbench

//   Game-time source for the top-level state machine. It debounces the raw active-low START

---
 rtl/sc_game_timer.sv | 159 +++++++++++++++
 tb/tb_sc_game_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_game_timer.sv
// Game-time source: debounces the START pushbutton, emits a one-cycle start strobe,
// then counts elapsed game seconds up to a terminal count.
module sc_game_timer #(
  parameter int unsigned TIME_WIDTH      = 4,
  parameter int unsigned TIME_MAX        = 9,
  parameter int unsigned PRESCALER_MAX   = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  SC_GAMETIMER_CLOCK_50,
  input  logic                  SC_GAMETIMER_RESET_InLow,
  input  logic                  SC_GAMETIMER_BUTTON_InLow,
  input  logic                  SC_GAMETIMER_CLEAR_InHigh,
  output logic [TIME_WIDTH-1:0] SC_GAMETIMER_TIME_OutBUS,
  output logic                  SC_GAMETIMER_START_OutLow,
  output logic                  SC_GAMETIMER_RUNNING_Out,
  output logic                  SC_GAMETIMER_DONE_Out,
  output logic                  SC_GAMETIMER_TICK_Out
);

  localparam int unsigned PRESC_W = (PRESCALER_MAX > 1) ? $clog2(PRESCALER_MAX) : 1;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(PRESCALER_MAX - 1);
  localparam logic [DB_W-1:0]       DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] TIME_END   = TIME_WIDTH'(TIME_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = SC_GAMETIMER_CLOCK_50;
  assign rst_n = SC_GAMETIMER_RESET_InLow;

  logic [1:0]      sync_q;
  logic [1:0]      sync_vld;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            armed;
  logic            press_c;

  // Synchronizer, debouncer and arming: a press only counts once a genuine
  // released level has been seen after reset, so a button held through reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      sync_vld <= 2'b00;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
      armed    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], SC_GAMETIMER_BUTTON_InLow};
      sync_vld <= {sync_vld[0], 1'b1};
      db_prev  <= db_level;
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_q[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (sync_vld[1] && sync_q[1] && db_level) begin
        armed <= 1'b1;
      end
    end
  end

  assign press_c = armed & db_prev & ~db_level;

  state_t               state;
  logic [TIME_WIDTH-1:0] time_q;
  logic [TIME_WIDTH-1:0] time_inc;
  logic [PRESC_W-1:0]    presc;
  logic                  start_n;
  logic                  running;
  logic                  done;
  logic                  tick;

  assign time_inc = time_q + TIME_WIDTH'(1);

  // Game FSM; tick is registered so it is high while the prescaler sits at its last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      time_q  <= '0;
      presc   <= '0;
      start_n <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      start_n <= 1'b1;
      tick    <= 1'b0;
      if (SC_GAMETIMER_CLEAR_InHigh) begin
        state   <= IDLE;
        time_q  <= '0;
        presc   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press_c) begin
              state   <= RUN;
              running <= 1'b1;
              start_n <= 1'b0;
              presc   <= '0;
              time_q  <= '0;
              tick    <= (PRESC_LAST == '0);
            end
          end
          RUN: begin
            if (presc == PRESC_LAST) begin
              presc  <= '0;
              time_q <= time_inc;
              if (time_inc == TIME_END) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end else begin
                tick <= (PRESC_LAST == '0);
              end
            end else begin
              presc <= presc + PRESC_W'(1);
              tick  <= ((presc + PRESC_W'(1)) == PRESC_LAST);
            end
          end
          DONE: begin
            if (press_c) begin
              state  <= IDLE;
              done   <= 1'b0;
              time_q <= '0;
            end
          end
          default: begin
            state   <= IDLE;
            time_q  <= '0;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SC_GAMETIMER_TIME_OutBUS  = time_q;
  assign SC_GAMETIMER_START_OutLow = start_n;
  assign SC_GAMETIMER_RUNNING_Out  = running;
  assign SC_GAMETIMER_DONE_Out     = done;
  assign SC_GAMETIMER_TICK_Out     = tick;

endmodule

// File: tb/tb_sc_game_timer.sv
// Bench for sc_game_timer: directed scenarios then random button/clear traffic,
// all checked against a behavioural model of the game timer.
module tb_sc_game_timer;

  localparam int unsigned TW   = 4;
  localparam int unsigned TMAX = 5;
  localparam int unsigned PMAX = 4;
  localparam int unsigned DC   = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          button = 1'b1;
  logic          clear  = 1'b0;
  logic [TW-1:0] time_o;
  logic          start_n;
  logic          running;
  logic          done;
  logic          tick;

  always #5 clk = ~clk;

  sc_game_timer #(
    .TIME_WIDTH     (TW),
    .TIME_MAX       (TMAX),
    .PRESCALER_MAX  (PMAX),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .SC_GAMETIMER_CLOCK_50    (clk),
    .SC_GAMETIMER_RESET_InLow (rst_n),
    .SC_GAMETIMER_BUTTON_InLow(button),
    .SC_GAMETIMER_CLEAR_InHigh(clear),
    .SC_GAMETIMER_TIME_OutBUS (time_o),
    .SC_GAMETIMER_START_OutLow(start_n),
    .SC_GAMETIMER_RUNNING_Out (running),
    .SC_GAMETIMER_DONE_Out    (done),
    .SC_GAMETIMER_TICK_Out    (tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int ticks    = 0;

  // Reference model: button history for debouncing, game progress as cycles since start.
  bit m_s1, m_s2, m_level, m_prev_level, m_armed;
  int m_edges;
  bit hist[$];
  int m_state;   // 0 idle, 1 run, 2 done
  int m_run;     // cycles elapsed since the start strobe cycle

  function automatic void model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_prev_level = 1'b1; m_armed = 1'b0;
    m_edges = 0; hist.delete(); m_state = 0; m_run = 0;
  endfunction

  function automatic void model_edge(bit b, bit c);
    bit press_now;
    bit all_diff;
    press_now = m_armed && m_prev_level && !m_level;
    if (c) begin
      m_state = 0; m_run = 0;
    end else begin
      case (m_state)
        0: if (press_now) begin m_state = 1; m_run = 0; end
        1: begin
          m_run++;
          if (m_run / int'(PMAX) >= int'(TMAX)) m_state = 2;
        end
        default: if (press_now) m_state = 0;
      endcase
    end
    m_prev_level = m_level;
    if (m_edges >= 2 && m_s2 && m_level) m_armed = 1'b1;
    hist.push_back(m_s2);
    if (hist.size() > int'(DC)) void'(hist.pop_front());
    all_diff = (hist.size() == int'(DC));
    foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
    if (all_diff) m_level = !m_level;
    m_s2 = m_s1;
    m_s1 = b;
    m_edges++;
  endfunction

  function automatic int exp_time();
    if (m_state == 0) return 0;
    if (m_state == 1) return m_run / int'(PMAX);
    return int'(TMAX);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_time"},    32'(time_o),  32'(exp_time()));
    check({tag, "_start_n"}, 32'(start_n), 32'(!(m_state == 1 && m_run == 0)));
    check({tag, "_running"}, 32'(running), 32'(m_state == 1));
    check({tag, "_done"},    32'(done),    32'(m_state == 2));
    check({tag, "_tick"},    32'(tick),    32'(m_state == 1 && (m_run % int'(PMAX)) == int'(PMAX) - 1));
  endtask

  task automatic step(input bit b, input bit c, input string tag);
    button = b;
    clear  = c;
    @(posedge clk);
    if (rst_n) model_edge(b, c);
    else model_reset();
    #1;
    if (start_n === 1'b0) strobes++;
    if (tick === 1'b1) ticks++;
    check_all(tag);
  endtask

  task automatic press(input int low, input int high, input string tag);
    for (int i = 0; i < low; i++) step(1'b0, 1'b0, tag);
    for (int i = 0; i < high; i++) step(1'b1, 1'b0, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit blevel;
    int dur;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "arm");

    // 1: async reset mid-run at TIME=3, then button held low through release
    press(6, 0, "t1_press");
    for (int i = 0; i < 40 && !(m_state == 1 && exp_time() == 3); i++) step(1'b1, 1'b0, "t1_run");
    check("t1_time3", 32'(time_o), 32'd3);
    button = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_time", 32'(time_o), 32'd0);
    check("t1_rst_running", 32'(running), 32'd0);
    check("t1_rst_start_n", 32'(start_n), 32'd1);
    check("t1_rst_tick", 32'(tick), 32'd0);
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "t1_inrst");
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, "t1_held");
    check("t1_held_no_start", 32'(strobes), 32'd0);
    check("t1_held_idle", 32'(running), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "t1_release");

    // 2: short bounce ignored, long press gives one strobe
    strobes = 0;
    press(2, 8, "t2_bounce");
    check("t2_bounce_no_start", 32'(strobes), 32'd0);
    check("t2_bounce_idle", 32'(running), 32'd0);
    ticks = 0;
    press(6, 4, "t2_press");
    check("t2_one_start", 32'(strobes), 32'd1);
    check("t2_running", 32'(running), 32'd1);

    // 3: count to terminal, then hold
    for (int i = 0; i < 40 && m_state != 2; i++) step(1'b1, 1'b0, "t3_count");
    check("t3_done", 32'(done), 32'd1);
    check("t3_time5", 32'(time_o), 32'd5);
    check("t3_tick_total", 32'(ticks), 32'd5);
    ticks = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "t3_hold");
    check("t3_hold_ticks", 32'(ticks), 32'd0);
    check("t3_hold_time", 32'(time_o), 32'd5);

    // 4: press in DONE -> IDLE, new start, press in RUN ignored
    press(6, 4, "t4_done_press");
    check("t4_idle_done", 32'(done), 32'd0);
    check("t4_idle_time", 32'(time_o), 32'd0);
    strobes = 0;
    press(6, 0, "t4_restart");
    check("t4_restart_strobe", 32'(strobes), 32'd1);
    for (int i = 0; i < 40 && !(m_state == 1 && exp_time() == 2); i++) step(1'b1, 1'b0, "t4_wait2");
    check("t4_time2", 32'(time_o), 32'd2);
    press(5, 3, "t4_run_press");
    check("t4_still_running", 32'(running), 32'd1);
    check("t4_no_new_strobe", 32'(strobes), 32'd1);
    for (int i = 0; i < 40 && m_state != 2; i++) step(1'b1, 1'b0, "t4_finish");
    check("t4_done", 32'(done), 32'd1);

    // 5: clear coincident with the TIME=3 tick
    press(6, 4, "t5_to_idle");
    press(6, 0, "t5_start");
    for (int i = 0; i < 40 && !(m_state == 1 && m_run == 3 * int'(PMAX) + int'(PMAX) - 1); i++)
      step(1'b1, 1'b0, "t5_wait");
    check("t5_tick_pre", 32'(tick), 32'd1);
    check("t5_time_pre", 32'(time_o), 32'd3);
    strobes = 0;
    step(1'b1, 1'b1, "t5_clear");
    check("t5_clear_time", 32'(time_o), 32'd0);
    check("t5_clear_idle", 32'(running), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "t5_after");
    check("t5_no_strobe", 32'(strobes), 32'd0);

    // Random button/clear traffic against the model
    blevel = 1'b1;
    dur = 0;
    for (int i = 0; i < 800; i++) begin
      if (dur == 0) begin
        blevel = !blevel;
        dur = int'($urandom_range(1, 8));
      end
      dur--;
      step(blevel, ($urandom_range(0, 39) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
